// File: rtl/bpsk_pkg.sv
// Shared types and constants for the BPSK receive deframer.
package bpsk_pkg;

  localparam int SYNC_LEN = 16;
  localparam logic [SYNC_LEN-1:0] SYNC_WORD_DEFAULT = 16'hF3A0;

  typedef enum logic {
    HUNT    = 1'b0,
    PAYLOAD = 1'b1
  } frame_state_e;

  function automatic logic [4:0] popcount16(input logic [SYNC_LEN-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < SYNC_LEN; i++) begin
      n = n + 5'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/bpsk_sync_correlator.sv
// Combinational sync-word correlator: Hamming distance against the word and its inverse.
module bpsk_sync_correlator
  import bpsk_pkg::*;
#(
  parameter int MAX_ERRS = 1
) (
  input  logic [SYNC_LEN-1:0] sr_i,
  input  logic [SYNC_LEN-1:0] sync_word_i,
  output logic                match_n_o,
  output logic                match_i_o
);

  logic [4:0] dist_n;
  logic [4:0] dist_i;

  always_comb begin
    dist_n    = popcount16(sr_i ^ sync_word_i);
    dist_i    = popcount16(sr_i ^ ~sync_word_i);
    match_n_o = (dist_n <= 5'(MAX_ERRS));
    match_i_o = (dist_i <= 5'(MAX_ERRS));
  end

endmodule

// File: rtl/bpsk_frame_sync.sv
// BPSK receive deframer: hunts for the sync word (either polarity), then packs the
// fixed-length payload into polarity-corrected bytes.
module bpsk_frame_sync
  import bpsk_pkg::*;
#(
  parameter logic [SYNC_LEN-1:0] SYNC_WORD     = SYNC_WORD_DEFAULT,
  parameter int                  PAYLOAD_BYTES = 8,
  parameter int                  MAX_ERRS      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_in,
  input  logic       bit_valid,
  input  logic       locked,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_start,
  output logic       frame_done,
  output logic       inverted,
  output logic       in_frame
);

  localparam logic [7:0] LAST_BYTE = 8'(PAYLOAD_BYTES - 1);
  localparam logic [4:0] HUNT_FULL = 5'(SYNC_LEN);

  frame_state_e        state_q, state_d;
  logic [SYNC_LEN-1:0] sr_q, sr_d;
  logic [4:0]          hunt_cnt_q, hunt_cnt_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [7:0]          byte_cnt_q, byte_cnt_d;
  logic [6:0]          byte_sr_q, byte_sr_d;
  logic [7:0]          byte_out_q, byte_out_d;
  logic                byte_valid_q, byte_valid_d;
  logic                frame_start_q, frame_start_d;
  logic                frame_done_q, frame_done_d;
  logic                inverted_q, inverted_d;
  logic                in_frame_q, in_frame_d;

  logic [SYNC_LEN-1:0] sr_next;
  logic [4:0]          hunt_cnt_next;
  logic [7:0]          byte_next;
  logic                match_n, match_i;

  assign sr_next       = {sr_q[SYNC_LEN-2:0], bit_in};
  assign hunt_cnt_next = (hunt_cnt_q == HUNT_FULL) ? hunt_cnt_q : hunt_cnt_q + 5'd1;
  assign byte_next     = {byte_sr_q, bit_in ^ inverted_q};

  bpsk_sync_correlator #(
    .MAX_ERRS(MAX_ERRS)
  ) u_corr (
    .sr_i       (sr_next),
    .sync_word_i(SYNC_WORD),
    .match_n_o  (match_n),
    .match_i_o  (match_i)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= HUNT;
      sr_q          <= '0;
      hunt_cnt_q    <= '0;
      bit_idx_q     <= '0;
      byte_cnt_q    <= '0;
      byte_sr_q     <= '0;
      byte_out_q    <= '0;
      byte_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      inverted_q    <= 1'b0;
      in_frame_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      sr_q          <= sr_d;
      hunt_cnt_q    <= hunt_cnt_d;
      bit_idx_q     <= bit_idx_d;
      byte_cnt_q    <= byte_cnt_d;
      byte_sr_q     <= byte_sr_d;
      byte_out_q    <= byte_out_d;
      byte_valid_q  <= byte_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      inverted_q    <= inverted_d;
      in_frame_q    <= in_frame_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    sr_d          = sr_q;
    hunt_cnt_d    = hunt_cnt_q;
    bit_idx_d     = bit_idx_q;
    byte_cnt_d    = byte_cnt_q;
    byte_sr_d     = byte_sr_q;
    byte_out_d    = byte_out_q;
    byte_valid_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    inverted_d    = inverted_q;
    in_frame_d    = in_frame_q;

    if (!locked) begin
      // Lock loss abandons any partial frame; inverted keeps the last frame's polarity.
      state_d    = HUNT;
      sr_d       = '0;
      hunt_cnt_d = '0;
      bit_idx_d  = '0;
      byte_cnt_d = '0;
      byte_sr_d  = '0;
      in_frame_d = 1'b0;
    end else if (bit_valid) begin
      case (state_q)
        HUNT: begin
          sr_d       = sr_next;
          hunt_cnt_d = hunt_cnt_next;
          if (hunt_cnt_next == HUNT_FULL && (match_n || match_i)) begin
            state_d       = PAYLOAD;
            inverted_d    = !match_n;
            frame_start_d = 1'b1;
            in_frame_d    = 1'b1;
            bit_idx_d     = '0;
            byte_cnt_d    = '0;
            byte_sr_d     = '0;
          end
        end
        PAYLOAD: begin
          if (bit_idx_q == 3'd7) begin
            bit_idx_d    = '0;
            byte_sr_d    = '0;
            byte_out_d   = byte_next;
            byte_valid_d = 1'b1;
            if (byte_cnt_q == LAST_BYTE) begin
              // Sync search restarts from an empty window so payload never aliases as sync.
              state_d      = HUNT;
              frame_done_d = 1'b1;
              in_frame_d   = 1'b0;
              byte_cnt_d   = '0;
              sr_d         = '0;
              hunt_cnt_d   = '0;
            end else begin
              byte_cnt_d = byte_cnt_q + 8'd1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            byte_sr_d = byte_next[6:0];
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign byte_out    = byte_out_q;
  assign byte_valid  = byte_valid_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign inverted    = inverted_q;
  assign in_frame    = in_frame_q;

endmodule

// File: tb/tb_bpsk_frame_sync.sv
// Bench for bpsk_frame_sync: frame table, hand-written corner sequences and a random
// stream, all checked cycle by cycle against a queue-based reference model.
module tb_bpsk_frame_sync;

  localparam logic [15:0] SW = 16'hF3A0;
  localparam int          PB = 8;
  localparam int          ME = 1;

  typedef logic [7:0] pay_t [PB];

  typedef struct {
    logic [15:0] sync;
    bit          invert;
    bit          rand_pay;
    bit          long_gap;
    int          exp_fs;
    int          exp_bytes;
    bit          exp_inv;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       locked = 1'b1;
  logic [7:0] byte_out;
  logic       byte_valid, frame_start, frame_done, inverted, in_frame;

  bpsk_frame_sync #(
    .SYNC_WORD    (SW),
    .PAYLOAD_BYTES(PB),
    .MAX_ERRS     (ME)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .locked     (locked),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .frame_start(frame_start),
    .frame_done (frame_done),
    .inverted   (inverted),
    .in_frame   (in_frame)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Event monitor
  int         n_bv = 0, n_fs = 0, n_fd = 0;
  logic [7:0] got_q[$];

  always @(negedge clk) begin
    if (byte_valid) begin
      n_bv++;
      got_q.push_back(byte_out);
    end
    if (frame_start) n_fs++;
    if (frame_done)  n_fd++;
  end

  // Reference model: sliding bit window while hunting, bit list while in payload
  bit         m_hunt = 1'b1;
  bit         q_win[$];
  bit         q_pay[$];
  int         m_nbytes = 0;
  logic [7:0] m_byte_out = '0;
  bit         m_bv = 0, m_fs = 0, m_fd = 0, m_inv = 0, m_inframe = 0;

  function automatic logic [15:0] win_word();
    logic [15:0] w;
    w = '0;
    foreach (q_win[i]) w = {w[14:0], q_win[i]};
    return w;
  endfunction

  task automatic model_step(input bit b);
    logic [15:0] w;
    logic [7:0]  by;
    m_bv = 0; m_fs = 0; m_fd = 0;
    if (m_hunt) begin
      q_win.push_back(b);
      if (q_win.size() > 16) void'(q_win.pop_front());
      if (q_win.size() == 16) begin
        w = win_word();
        if ($countones(w ^ SW) <= ME || $countones(w ^ ~SW) <= ME) begin
          m_inv     = !($countones(w ^ SW) <= ME);
          m_hunt    = 0;
          m_fs      = 1;
          m_inframe = 1;
          m_nbytes  = 0;
          q_pay.delete();
        end
      end
    end else begin
      q_pay.push_back(b ^ m_inv);
      if (q_pay.size() == 8) begin
        by = '0;
        foreach (q_pay[i]) by = {by[6:0], q_pay[i]};
        q_pay.delete();
        m_byte_out = by;
        m_bv       = 1;
        m_nbytes++;
        if (m_nbytes == PB) begin
          m_fd      = 1;
          m_hunt    = 1;
          m_inframe = 0;
          q_win.delete();
        end
      end
    end
  endtask

  task automatic model_idle();
    m_bv = 0; m_fs = 0; m_fd = 0;
  endtask

  task automatic model_lock_loss();
    model_idle();
    m_hunt = 1; m_inframe = 0; m_nbytes = 0;
    q_win.delete();
    q_pay.delete();
  endtask

  task automatic model_reset();
    model_lock_loss();
    m_inv = 0;
    m_byte_out = '0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".byte_out"},    32'(byte_out),    32'(m_byte_out));
    chk({tag, ".byte_valid"},  32'(byte_valid),  32'(m_bv));
    chk({tag, ".frame_start"}, 32'(frame_start), 32'(m_fs));
    chk({tag, ".frame_done"},  32'(frame_done),  32'(m_fd));
    chk({tag, ".inverted"},    32'(inverted),    32'(m_inv));
    chk({tag, ".in_frame"},    32'(in_frame),    32'(m_inframe));
  endtask

  // Stimulus helpers
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bit_valid = 1'b0;
      bit_in    = 1'($urandom);
      @(posedge clk); #1;
      model_idle();
      check_all("idle");
    end
  endtask

  task automatic strobe(input logic b, input int gap);
    bit_in    = b;
    bit_valid = 1'b1;
    @(posedge clk); #1;
    model_step(b);
    check_all("strobe");
    bit_valid = 1'b0;
    if (gap > 1) idle(gap - 1);
  endtask

  task automatic send_word(input logic [15:0] w, input int nbits, input bit inv, input int gap);
    for (int i = nbits - 1; i >= 0; i--) strobe(w[i] ^ inv, gap);
  endtask

  task automatic send_frame(input logic [15:0] sync, input pay_t p, input bit inv,
                            input bit long_gap, input int npre);
    for (int i = 0; i < npre; i++) strobe(1'($urandom), 1 + int'($urandom_range(0, 1)));
    send_word(sync, 16, inv, 1);
    for (int k = 0; k < PB; k++) send_word({8'h00, p[k]}, 8, inv, (long_gap && k == 0) ? 2000 : 1);
  endtask

  task automatic lock_drop(input logic with_strobe);
    locked    = 1'b0;
    bit_valid = with_strobe;
    bit_in    = 1'($urandom);
    @(posedge clk); #1;
    model_lock_loss();
    check_all("lockloss");
    locked    = 1'b1;
    bit_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    @(posedge clk); #1;
    model_reset();
    check_all("reset");
    rst       = 1'b0;
    bit_valid = 1'b0;
  endtask

  task automatic check_bytes(input string tag, input pay_t p, input int first);
    for (int k = 0; k < PB; k++) begin
      if (got_q.size() > first + k) chk(tag, 32'(got_q[first + k]), 32'(p[k]));
    end
  endtask

  vec_t vecs[7];
  pay_t fixed_pay, pay, pay2;
  int   fs0, fd0, bv0;

  initial begin
    fixed_pay = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    //          sync      inv rnd long fs bytes inv
    vecs[0] = '{16'hF3A0, 0, 0, 0, 1, 8, 0};
    vecs[1] = '{16'hF3A0, 1, 0, 0, 1, 8, 1};
    vecs[2] = '{16'hF3A1, 0, 0, 0, 1, 8, 0};
    vecs[3] = '{16'hF3A3, 0, 0, 0, 0, 0, 0};
    vecs[4] = '{16'hF3A0, 0, 0, 1, 1, 8, 0};
    vecs[5] = '{16'hF3A0, 0, 1, 0, 1, 8, 0};
    vecs[6] = '{16'hF3A1, 1, 1, 0, 1, 8, 1};

    @(posedge clk); #1;
    @(posedge clk); #1;
    model_reset();
    check_all("por");
    rst = 1'b0;
    idle(4);

    for (int v = 0; v < 7; v++) begin
      lock_drop(1'b0);
      for (int k = 0; k < PB; k++) pay[k] = vecs[v].rand_pay ? 8'($urandom) : fixed_pay[k];
      got_q.delete();
      fs0 = n_fs; fd0 = n_fd; bv0 = n_bv;
      send_frame(vecs[v].sync, pay, vecs[v].invert, vecs[v].long_gap, 5);
      idle(2);
      chk("vec.frame_start_cnt", 32'(n_fs - fs0), 32'(vecs[v].exp_fs));
      chk("vec.byte_cnt",        32'(n_bv - bv0), 32'(vecs[v].exp_bytes));
      chk("vec.frame_done_cnt",  32'(n_fd - fd0), 32'(vecs[v].exp_bytes == PB ? 1 : 0));
      if (vecs[v].exp_fs != 0) chk("vec.inverted", 32'(inverted), 32'(vecs[v].exp_inv));
      check_bytes("vec.byte", pay, 0);
    end

    // Lock loss after 3.5 payload bytes, with a strobe in the lock-loss cycle
    lock_drop(1'b0);
    fs0 = n_fs; fd0 = n_fd; bv0 = n_bv;
    for (int i = 0; i < 5; i++) strobe(1'($urandom), 1);
    send_word(SW, 16, 0, 1);
    for (int k = 0; k < 3; k++) send_word({8'h00, fixed_pay[k]}, 8, 0, 1);
    send_word({8'h00, fixed_pay[3]}, 4, 0, 1);
    lock_drop(1'b1);
    idle(3);
    chk("lockloss.byte_cnt",       32'(n_bv - bv0), 32'd3);
    chk("lockloss.frame_done_cnt", 32'(n_fd - fd0), 32'd0);
    got_q.delete();
    send_frame(SW, fixed_pay, 0, 0, 3);
    idle(2);
    chk("lockloss.next_bytes", 32'(got_q.size()), 32'(PB));
    check_bytes("lockloss.next_byte", fixed_pay, 0);

    // Reset mid-payload, then a fresh inverted frame
    lock_drop(1'b0);
    for (int i = 0; i < 5; i++) strobe(1'($urandom), 1);
    send_word(SW, 16, 0, 1);
    send_word(16'h5A5A, 16, 0, 1);
    send_word(16'h0003, 4, 0, 1);
    do_reset();
    chk("reset.byte_out", 32'(byte_out), 32'd0);
    got_q.delete();
    send_frame(SW, fixed_pay, 1, 0, 2);
    idle(2);
    chk("reset.next_bytes", 32'(got_q.size()), 32'(PB));
    check_bytes("reset.next_byte", fixed_pay, 0);

    // Back-to-back frames, first payload carrying the sync pattern itself
    lock_drop(1'b0);
    pay  = '{8'hF3, 8'hA0, 8'h0C, 8'h5F, 8'hF3, 8'hA1, 8'h00, 8'hFF};
    pay2 = fixed_pay;
    got_q.delete();
    fs0 = n_fs; fd0 = n_fd;
    send_frame(SW, pay, 0, 0, 5);
    send_frame(SW, pay2, 0, 0, 0);
    idle(2);
    chk("b2b.frame_start_cnt", 32'(n_fs - fs0), 32'd2);
    chk("b2b.frame_done_cnt",  32'(n_fd - fd0), 32'd2);
    chk("b2b.bytes",           32'(got_q.size()), 32'(2 * PB));
    check_bytes("b2b.byte1", pay, 0);
    check_bytes("b2b.byte2", pay2, PB);

    // Random stream with injected (possibly corrupted) sync words and lock drops
    for (int s = 0; s < 400; s++) begin
      int          r;
      logic [15:0] w;
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        lock_drop(1'($urandom));
      end else if (m_hunt && r < 12) begin
        w = $urandom_range(0, 1) ? SW : ~SW;
        if ($urandom_range(0, 2) == 0) w[$urandom_range(0, 15)] ^= 1'b1;
        if ($urandom_range(0, 4) == 0) w[$urandom_range(0, 15)] ^= 1'b1;
        send_word(w, 16, 0, int'($urandom_range(1, 2)));
      end else begin
        strobe(1'($urandom), int'($urandom_range(1, 3)));
      end
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/bpsk_frame_sync.md
Name: bpsk_frame_sync

Overview:
- Receive-side deframer behind the BPSK demodulator. It takes the recovered serial bit stream plus a one-cycle bit strobe.
- Hunts for a 16-bit sync word, or its bitwise inverse, which resolves the 180-degree Costas phase ambiguity.
- After sync is found, it assembles a fixed-length payload into bytes with polarity corrected.
- It is the receiving counterpart of the transmit-side framer feeding the modulator's data_in.

Parameters:
- SYNC_WORD, 16'hF3A0, sync pattern, transmitted MSB first.
- PAYLOAD_BYTES, 8, payload bytes per frame (range 1..255).
- MAX_ERRS, 1, maximum Hamming distance accepted as a sync match (range 0..3).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous reset, active-high.
- bit_in  in  1  demodulated data bit, sampled only when bit_valid=1.
- bit_valid  in  1  one-cycle strobe, one per symbol (nominally every 2000 clk).
- locked  in  1  Costas lock indication; low forces hunt.
- byte_out  out  8  assembled payload byte, MSB = first received bit.
- byte_valid  out  1  one-cycle pulse; byte_out is valid in that cycle.
- frame_start  out  1  one-cycle pulse when sync is detected.
- frame_done  out  1  one-cycle pulse coincident with the last byte_valid of a frame.
- inverted  out  1  1 = frame was found via the inverted sync word; payload bits are being complemented.
- in_frame  out  1  high while in the PAYLOAD state.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State=HUNT; shift register=0; hunt bit count=0; bit index=0; byte count=0.
  - byte_out=0; byte_valid, frame_start, frame_done, inverted and in_frame all 0.
  - Reset wins over every other input in the same cycle.
- All outputs are registered. Pulses are high for exactly one cycle.
- Inputs with bit_valid=0 are ignored entirely.
- HUNT state, on each bit_valid:
  - Shift left: sr <= {sr[14:0], bit_in}.
  - Hunt count increments, saturating at 16.
  - Match test uses the post-shift value, and only once hunt count (after increment) is 16.
  - dN = popcount(sr_next XOR SYNC_WORD); dI = popcount(sr_next XOR ~SYNC_WORD).
  - If dN <= MAX_ERRS: go to PAYLOAD, inverted <= 0.
  - Else if dI <= MAX_ERRS: go to PAYLOAD, inverted <= 1.
  - Normal polarity has priority when both conditions hold.
  - On either match, frame_start pulses in the next cycle, together with in_frame rising.
- PAYLOAD state, on each bit_valid:
  - Corrected bit b = bit_in XOR inverted, shifted into a byte register MSB first.
  - Bit index 0..7 wraps. On the 8th bit, byte_out is loaded with the complete byte and byte_valid pulses in the next cycle.
  - Byte count increments per byte.
  - When byte count reaches PAYLOAD_BYTES:
    - frame_done pulses with that byte_valid.
    - State returns to HUNT; shift register, hunt count and bit index are cleared.
    - inverted holds its value until the next frame_start.
- Latency:
  - byte_valid is 1 clk after the bit_valid carrying bit 7 of the byte.
  - frame_start is 1 clk after the bit_valid completing the sync word.
- Lock loss:
  - Any cycle with locked=0 forces HUNT and clears the shift register, counts and in_frame.
  - No byte_valid or frame_done is produced for a partial byte or frame.
  - A bit_valid in the same cycle is discarded.
- Back-to-back frames: the sync search restarts from zero bits after frame_done. Payload bits never contribute to sync detection.
- byte_out holds its last value between pulses.

Decomposition:
- Shared package bpsk_pkg:
  - Frame state enum (HUNT, PAYLOAD).
  - SYNC_LEN=16.
  - Default SYNC_WORD constant.
- One sub-module: bpsk_sync_correlator.
  - Combinational 16-bit XOR plus popcount.
  - Outputs match_n and match_i against MAX_ERRS.
  - Instantiated once; inputs are sr_next and SYNC_WORD.

Test Plan:
- Nominal frame:
  - Stimulus: locked=1, 5 random bits, then F3A0, then payload 01 23 45 67 89 AB CD EF.
  - Required: frame_start once, inverted=0, eight byte_valid with those values, frame_done on the 8th.
- Inverted frame:
  - Stimulus: same stream with every bit complemented (sync 0C5F).
  - Required: inverted=1, bytes still 01..EF.
- Error tolerance:
  - Stimulus: sync F3A1 (1 bit error) locks. Sync F3A3 (2 errors) with MAX_ERRS=1.
  - Required: F3A1 gives a frame. F3A3 gives no frame_start and stays in HUNT.
- Lock loss:
  - Stimulus: locked drops for 1 cycle after 3.5 payload bytes.
  - Required: exactly 3 byte_valid, no frame_done. A following full frame decodes correctly.
- Strobe spacing and reset:
  - Stimulus: bit_valid with gaps of 1 and 2000 cycles, idle input toggling with bit_valid=0.
  - Required: identical byte results for both gap lengths; idle toggling has no effect.
  - Stimulus: rst mid-payload.
  - Required: all outputs 0 next cycle, and the next frame decodes.
- Back-to-back frames:
  - Stimulus: two frames with no gap, the first payload containing the bytes F3 A0.
  - Required: no false frame_start inside the payload; two frame_done pulses.
